// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter that shares one AXI-Stream
// master link among NUM_SRC upstream sources. A grant is held for a whole
// packet and released only on the accepted tlast beat, so packets never
// interleave. One IDLE cycle separates consecutive packets.
//
// Ports:
//   axis_aclk      clock, rising edge
//   axis_arst      synchronous active-high reset
//   s_axis_tdata   NUM_SRC*DATA_W source data, source i at [i*DATA_W +: DATA_W]
//   s_axis_tvalid  per-source valid
//   s_axis_tlast   per-source last
//   s_axis_tready  per-source ready (only the granted source sees m_axis_tready)
//   m_axis_tdata   output data (zero when not granted)
//   m_axis_tvalid  output valid
//   m_axis_tlast   output last (qualified by the granted source's valid)
//   m_axis_tready  downstream ready
//   grant_id       index of the granted source, 0 when not busy
//   busy           high while a packet is granted
//   pkt_count      (AXIS_ARB_PKT_CNT_EN only) 16-bit accepted-packet counter
//                  per source, source i at [i*16 +: 16]
//
// Optional feature macro: AXIS_ARB_PKT_CNT_EN adds the pkt_count output.

module axis_rr_arbiter #(
  parameter  int unsigned NUM_SRC = 3,
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned GRANT_W = $clog2(NUM_SRC)
) (
  input  logic                        axis_aclk,
  input  logic                        axis_arst,
  input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        busy
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC*16-1:0]       pkt_count
`endif
);

  localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_SRC - 1);

  // Two-bit encoding leaves room for illegal codes, which recover to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01
  } state_t;

  state_t               r_state;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   r_last_grant;
  logic                 r_busy;

  logic                 w_req_any;
  logic                 w_found;
  logic [GRANT_W-1:0]   w_idx;
  logic [GRANT_W-1:0]   w_pick;

  logic [DATA_W-1:0]    w_tdata;
  logic                 w_tvalid;
  logic                 w_tlast;
  logic [NUM_SRC-1:0]   w_tready;
  logic                 w_accept_last;

  // Round-robin pick: first requester scanning upward from last_grant+1.
  always_comb begin
    w_req_any = |s_axis_tvalid;
    w_found   = 1'b0;
    w_idx     = '0;
    w_pick    = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      w_idx = GRANT_W'((32'(r_last_grant) + k) % NUM_SRC);
      if (!w_found && s_axis_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Zero-latency pass-through of the granted source; everything idle otherwise.
  always_comb begin
    w_tdata  = '0;
    w_tvalid = 1'b0;
    w_tlast  = 1'b0;
    w_tready = '0;
    if (r_state == ST_GRANT) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (r_grant == GRANT_W'(i)) begin
          w_tdata     = s_axis_tdata[i*DATA_W +: DATA_W];
          w_tvalid    = s_axis_tvalid[i];
          w_tlast     = s_axis_tvalid[i] & s_axis_tlast[i];
          w_tready[i] = m_axis_tready;
        end
      end
    end
  end

  // w_tlast already carries the granted source's valid.
  assign w_accept_last = w_tlast & m_axis_tready;

  // Arbitration FSM.
  always_ff @(posedge axis_aclk) begin
    if (axis_arst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_IDX;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant <= w_pick;
            r_state <= ST_GRANT;
            r_busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (w_accept_last) begin
            r_last_grant <= r_grant;
            r_grant      <= '0;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = w_tdata;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign s_axis_tready = w_tready;
  assign grant_id      = r_grant;
  assign busy          = r_busy;

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_SRC*16-1:0] r_pkt_count;

  // Per-source accepted-packet counters, wrapping at 16 bits.
  always_ff @(posedge axis_aclk) begin
    if (axis_arst) begin
      r_pkt_count <= '0;
    end else if (w_accept_last) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (r_grant == GRANT_W'(i)) begin
          r_pkt_count[i*16 +: 16] <= r_pkt_count[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: a packet-level behavioural model
// checked against the DUT on every cycle, plus directed literal expectations.

module tb_axis_rr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned GW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [GW-1:0]     grant_id;
  logic              busy;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [N*16-1:0]   pkt_count;
`endif

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(DW)) dut (
    .axis_aclk     (clk),
    .axis_arst     (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_id      (grant_id),
    .busy          (busy)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- source engine: packets of len beats per source ----------
  int          pkts_left [N];
  int          beat      [N];
  int          len       [N];
  int          pkt       [N];
  logic [7:0]  base      [N];
  logic [N-1:0] hs_q;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = (pkts_left[i] > 0);
      s_tlast[i]  = (beat[i] == len[i] - 1);
      s_tdata[i*DW +: DW] = 8'(int'(base[i]) + 17 * beat[i] + 64 * pkt[i]);
    end
  endtask

  task automatic load(input int i, input int npk, input int ln, input logic [7:0] b);
    pkts_left[i] = npk;
    len[i]       = ln;
    beat[i]      = 0;
    pkt[i]       = 0;
    base[i]      = b;
    drive();
  endtask

  function automatic bit any_left();
    bit r;
    r = 1'b0;
    for (int i = 0; i < N; i++) if (pkts_left[i] > 0) r = 1'b1;
    return r;
  endfunction

  always @(negedge clk) hs_q = s_tvalid & s_tready;

  // Advance one clock; sources step past beats handshaken in that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_q[i] === 1'b1) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]++;
          pkts_left[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
  endtask

  // ---------------- behavioural model ----------------------------------------
  bit md_busy = 1'b0;
  int md_g    = 0;
  int md_last = N - 1;
  int md_cnt [N];

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    int p;
    int idx;
    p = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (p < 0 && req[idx]) p = idx;
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      md_busy = 1'b0;
      md_g    = 0;
      md_last = N - 1;
      for (int i = 0; i < N; i++) md_cnt[i] = 0;
    end else if (!md_busy) begin
      if (|s_tvalid) begin
        md_g    = rr_pick(md_last, s_tvalid);
        md_busy = 1'b1;
      end
    end else if (s_tvalid[md_g] && s_tlast[md_g] && m_tready) begin
      md_last      = md_g;
      md_cnt[md_g] = (md_cnt[md_g] + 1) % 65536;
      md_busy      = 1'b0;
      md_g         = 0;
    end
  end

  // ---------------- per-cycle compare + observation logs --------------------
  bit         chk_en = 1'b0;
  logic       prev_busy = 1'b0;
  int         gq[$];
  logic [8:0] bq[$];

  always @(negedge clk) begin : cmp
    logic [DW-1:0] e_d;
    logic          e_v;
    logic          e_l;
    logic [N-1:0]  e_r;
    if (chk_en) begin
      e_d = '0; e_v = 1'b0; e_l = 1'b0; e_r = '0;
      if (md_busy) begin
        e_d = s_tdata[md_g*DW +: DW];
        e_v = s_tvalid[md_g];
        e_l = s_tvalid[md_g] & s_tlast[md_g];
        e_r = N'(m_tready) << md_g;
      end
      check("busy",     32'(busy),     32'(md_busy));
      check("grant_id", 32'(grant_id), 32'(md_g));
      check("m_tvalid", 32'(m_tvalid), 32'(e_v));
      check("m_tdata",  32'(m_tdata),  32'(e_d));
      check("m_tlast",  32'(m_tlast),  32'(e_l));
      check("s_tready", 32'(s_tready), 32'(e_r));
`ifdef AXIS_ARB_PKT_CNT_EN
      for (int i = 0; i < N; i++)
        check($sformatf("pkt_count%0d", i), 32'(pkt_count[i*16 +: 16]), 32'(md_cnt[i]));
`endif
      if (busy && !prev_busy) gq.push_back(int'(grant_id));
      if (m_tvalid && m_tready) bq.push_back({m_tlast, m_tdata});
      prev_busy = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ---------------------------------------
  initial begin : stim
    int n;
    rst      = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 1, 1, 8'h00);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset with every source requesting.
    repeat (2) begin
      @(negedge clk);
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tready", 32'(s_tready), 32'd0);
      check("rst_busy",   32'(busy),     32'd0);
      check("rst_grant",  32'(grant_id), 32'd0);
      tick();
    end
    for (int i = 0; i < N; i++) pkts_left[i] = 0;
    drive();
    rst = 1'b0;
    tick();

    // Round-robin with all sources sending two 2-beat packets.
    gq.delete();
    load(0, 2, 2, 8'h00);
    load(1, 2, 2, 8'h01);
    load(2, 2, 2, 8'h02);
    n = 0;
    while (any_left() && n < 200) begin tick(); n++; end
    check("rr_cycles", 32'(n), 32'd18);
    check("rr_count",  32'(gq.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("rr_grant%0d", k), 32'(k < gq.size() ? gq[k] : 99), 32'(k % 3));

    // Single source, 3 beats 11/22/33.
    bq.delete();
    load(1, 1, 3, 8'h11);
    @(negedge clk);
    check("ss_idle_tvalid", 32'(m_tvalid), 32'd0);
    check("ss_idle_busy",   32'(busy),     32'd0);
    tick();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check($sformatf("ss_tvalid%0d", b), 32'(m_tvalid), 32'd1);
      check($sformatf("ss_tdata%0d", b),  32'(m_tdata),  32'(17 * (b + 1)));
      check($sformatf("ss_tlast%0d", b),  32'(m_tlast),  32'(b == 2));
      check($sformatf("ss_grant%0d", b),  32'(grant_id), 32'd1);
      tick();
    end
    @(negedge clk);
    check("ss_busy_drop", 32'(busy), 32'd0);
    check("ss_beats", 32'(bq.size()), 32'd3);
    if (bq.size() == 3) begin
      check("ss_log0", 32'(bq[0]), 32'h011);
      check("ss_log1", 32'(bq[1]), 32'h022);
      check("ss_log2", 32'(bq[2]), 32'h133);
    end
    tick();

    // Backpressure mid-packet on source 0 (beats 05/16/27/38).
    bq.delete();
    load(0, 1, 4, 8'h05);
    tick();
    tick();
    tick();
    m_tready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_tdata",  32'(m_tdata),  32'h27);
      check("bp_tvalid", 32'(m_tvalid), 32'd1);
      check("bp_tready", 32'(s_tready), 32'd0);
      check("bp_grant",  32'(grant_id), 32'd0);
      check("bp_busy",   32'(busy),     32'd1);
      tick();
    end
    m_tready = 1'b1;
    n = 0;
    while (pkts_left[0] > 0 && n < 20) begin tick(); n++; end
    check("bp_resume_cycles", 32'(n), 32'd2);
    check("bp_beats", 32'(bq.size()), 32'd4);
    if (bq.size() == 4) begin
      check("bp_log0", 32'(bq[0]), 32'h005);
      check("bp_log1", 32'(bq[1]), 32'h016);
      check("bp_log2", 32'(bq[2]), 32'h027);
      check("bp_log3", 32'(bq[3]), 32'h138);
    end
    tick();

    // Reset on beat 2 of a 4-beat packet from source 2.
    load(2, 1, 4, 8'h0A);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mr_grant_before", 32'(grant_id), 32'd2);
    check("mr_tdata_before", 32'(m_tdata),  32'h1B);
    tick();
    pkts_left[2] = 0;
    beat[2]      = 0;
    rst          = 1'b0;
    drive();
    @(negedge clk);
    check("mr_busy",   32'(busy),     32'd0);
    check("mr_tvalid", 32'(m_tvalid), 32'd0);
    check("mr_tdata",  32'(m_tdata),  32'd0);
    check("mr_tlast",  32'(m_tlast),  32'd0);
    check("mr_tready", 32'(s_tready), 32'd0);
    check("mr_grant",  32'(grant_id), 32'd0);
    gq.delete();
    tick();
    load(0, 1, 1, 8'h50);
    load(1, 1, 1, 8'h60);
    load(2, 1, 1, 8'h70);
    n = 0;
    while (any_left() && n < 50) begin tick(); n++; end
    check("mr_count", 32'(gq.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("mr_grant%0d", k), 32'(k < gq.size() ? gq[k] : 99), 32'(k));
    tick();

`ifdef AXIS_ARB_PKT_CNT_EN
    // Packet counters: 2 packets from source 0, 5 from source 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load(0, 2, 1, 8'h80);
    load(1, 5, 1, 8'h90);
    n = 0;
    while (any_left() && n < 100) begin tick(); n++; end
    tick();
    @(negedge clk);
    check("pc_src0", 32'(pkt_count[0 +: 16]),  32'd2);
    check("pc_src1", 32'(pkt_count[16 +: 16]), 32'd5);
    check("pc_src2", 32'(pkt_count[32 +: 16]), 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
